pc_stack: RTL and testbench
===========================

PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 8: address width of the PC and all address ports.
REQ-002 SHALL have parameter DEPTH, default 4: return-address stack entries, legal range 2..16.
REQ-003 SHALL have parameter RESET_VEC, default 0: PC value loaded on reset.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-006 w  input  1  load PC from pc_inout.
REQ-007 r  input  1  drive PC onto pc_inout.
REQ-008 i  input  1  increment PC.
REQ-009 rel  input  1  PC-relative branch by off.
REQ-010 off  input  WIDTH  two's-complement branch offset.
REQ-011 call  input  1  push return address, jump to pc_inout.
REQ-012 ret  input  1  pop return address into PC.
REQ-013 pc_inout  inout  WIDTH  shared data bus; high-Z when not driven.
REQ-014 pc_out  output  WIDTH  current PC, always driven.
REQ-015 full, empty  output  1 each  stack occupancy == DEPTH / == 0.
REQ-016 ovf, unf  output  1 each  sticky overflow (call when full) / underflow (ret when empty).

Function
REQ-017 SHALL apply exactly one PC update per cycle, priority: w > call > ret > rel > i; lower-priority requests in the same cycle are discarded.
REQ-018 w: PC <= pc_inout next edge; stack unchanged.
REQ-019 call, not full: stack[sp] <= PC+1 (mod 2^WIDTH), sp <= sp+1, PC <= pc_inout.
REQ-020 call when full: no push, PC unchanged, ovf <= 1; existing entries preserved.
REQ-021 ret, not empty: PC <= stack[sp-1], sp <= sp-1.
REQ-022 ret when empty: PC unchanged, sp unchanged, unf <= 1.
REQ-023 rel: PC <= PC + off, sign-extended arithmetic, result truncated mod 2^WIDTH.
REQ-024 i: PC <= PC+1, wrapping 2^WIDTH-1 -> 0.
REQ-025 no request: PC holds.
REQ-026 pc_inout SHALL be driven with current (pre-edge) PC when r=1 and w=0 and call=0, else high-Z; r never blocks an update.
REQ-027 pc_out, full, empty SHALL reflect registered state combinationally with zero added latency; update visible the cycle after the triggering edge.
REQ-028 ovf/unf SHALL remain set until reset; not cleared by a later successful call/ret.
REQ-029 call and ret together: call wins per REQ-017; ret ignored, no flag set.

Reset
REQ-030 reset=0 at a rising edge: PC <= RESET_VEC, sp <= 0, ovf <= 0, unf <= 0, overriding all requests.
REQ-031 After reset: pc_out=RESET_VEC, empty=1, full=0, pc_inout high-Z unless r=1.
REQ-032 Stack entry contents need not be reset; they are unreadable while empty.
REQ-033 Reset asserted mid-sequence (e.g. stack partly filled) SHALL discard all stack contents.

Structure
REQ-034 Package pc_pkg SHALL hold the priority/op encoding constants and the DEPTH legality check constant.
REQ-035 The LIFO SHALL be a sub-module ras_stack (DEPTH x WIDTH, push/pop/full/empty), instantiated once.
REQ-036 sp width SHALL be $clog2(DEPTH+1) bits.

Verification
REQ-037 Reset, then i x3 -> pc_out = 3; r=1 -> pc_inout = 3.
REQ-038 WIDTH=8, w with bus=0xFE, then i x2 -> pc_out 0xFF, then 0x00.
REQ-039 PC=0x10, rel off=0xF0 -> PC=0x00; off=0x05 -> PC=0x05.
REQ-040 PC=0x20, call bus=0x80 -> PC=0x80, empty=0; ret -> PC=0x21, empty=1.
REQ-041 DEPTH=4: five calls -> full=1, ovf=1, PC = fourth target; four rets unwind correctly; fifth ret -> unf=1, PC held.
REQ-042 w, call, i in same cycle with r=1 -> only w takes effect, pc_inout not driven by block; reset low mid-stack -> PC=RESET_VEC, empty=1, flags 0.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared op encoding, update priority and DEPTH legality limits for pc_stack
package pc_pkg;
   typedef enum logic [2:0] {OP_NONE, OP_W, OP_CALL, OP_RET, OP_REL, OP_INC} op_e;
   localparam int DEPTH_MIN = 2;
   localparam int DEPTH_MAX = 16;
   function automatic op_e pick_op(input logic w, input logic call, input logic ret, input logic rel, input logic inc);
      return w ? OP_W : call ? OP_CALL : ret ? OP_RET : rel ? OP_REL : inc ? OP_INC : OP_NONE;
   endfunction
   function automatic bit depth_ok(input int d);
      return d >= DEPTH_MIN && d <= DEPTH_MAX;
   endfunction
endpackage

// File: rtl/pc_stack_ras_stack.sv
// ras_stack: DEPTH x WIDTH return-address LIFO; entries are not reset, only the pointer
module ras_stack import pc_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int SPW = $clog2(DEPTH + 1);
   localparam int AW  = $clog2(DEPTH);
   logic [SPW-1:0] sp_q, sp_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("ras_stack DEPTH out of range");
   end
   // pointer moves up on a push and down on a pop; callers never request both
   always_comb sp_d = push ? sp_q + 1'b1 : pop ? sp_q - 1'b1 : sp_q;
   // pointer flop, cleared by reset so old entries become unreachable
   always_ff @(posedge clk) begin
      if (!reset) sp_q <= '0;
      else        sp_q <= sp_d;
   end
   // entry storage, written at the current pointer on push
   always_ff @(posedge clk) begin
      if (push) mem_q[AW'(sp_q)] <= din;
   end
   assign dout  = mem_q[AW'(sp_q - 1'b1)];
   assign full  = sp_q == SPW'(DEPTH);
   assign empty = sp_q == '0;
endmodule

// File: rtl/pc_stack.sv
// pc_stack: program counter with load/inc/relative branch and a call/return address stack
module pc_stack import pc_pkg::*; #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int RESET_VEC = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             w,
   input  logic             r,
   input  logic             i,
   input  logic             rel,
   input  logic [WIDTH-1:0] off,
   input  logic             call,
   input  logic             ret,
   inout  wire  [WIDTH-1:0] pc_inout,
   output logic [WIDTH-1:0] pc_out,
   output logic             full,
   output logic             empty,
   output logic             ovf,
   output logic             unf
);
   op_e op;
   logic [WIDTH-1:0] pc_q, pc_d, ret_addr, pc_inc;
   logic push, pop, ovf_q, ovf_d, unf_q, unf_d;
   // pick the single winning request and compute next PC and sticky flags
   always_comb begin
      op     = pick_op(w, call, ret, rel, i);
      pc_inc = pc_q + 1'b1;
      push   = op == OP_CALL && !full;
      pop    = op == OP_RET && !empty;
      pc_d   = op == OP_W ? pc_inout : push ? pc_inout : pop ? ret_addr :
               op == OP_REL ? pc_q + off : op == OP_INC ? pc_inc : pc_q;
      ovf_d  = ovf_q | (op == OP_CALL && full);
      unf_d  = unf_q | (op == OP_RET && empty);
   end
   // PC and flag registers; reset overrides every request
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q  <= WIDTH'(RESET_VEC);
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end
   ras_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ras (
      .clk(clk), .reset(reset), .push(push), .pop(pop),
      .din(pc_inc), .dout(ret_addr), .full(full), .empty(empty)
   );
   // bus is released whenever something else may be driving a load target
   assign pc_inout = (r && !w && !call) ? pc_q : {WIDTH{1'bz}};
   assign pc_out   = pc_q;
   assign ovf      = ovf_q;
   assign unf      = unf_q;
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed vector table plus randomized run against a queue-based model
module tb_pc_stack;
   localparam int W = 8;
   localparam int D = 4;
   logic clk = 0, reset = 1, w = 0, r = 0, i = 0, rel = 0, call = 0, ret = 0;
   logic [W-1:0] off = '0, bus_val = '0;
   logic bus_en = 0;
   wire  [W-1:0] pc_inout;
   logic [W-1:0] pc_out;
   logic full, empty, ovf, unf;
   int n_cmp = 0, n_bad = 0;
   assign pc_inout = bus_en ? bus_val : {W{1'bz}};
   pc_stack #(.WIDTH(W), .DEPTH(D), .RESET_VEC(0)) dut (
      .clk(clk), .reset(reset), .w(w), .r(r), .i(i), .rel(rel), .off(off),
      .call(call), .ret(ret), .pc_inout(pc_inout), .pc_out(pc_out),
      .full(full), .empty(empty), .ovf(ovf), .unf(unf)
   );
   always #5 clk = ~clk;

   typedef struct {
      bit rst, w, r, i, rel, call, ret;
      logic [7:0] off, bus, pc;
      bit f, e, o, u, cb;
      logic [7:0] eb;
   } vec_t;
   vec_t tbl[$];

   // behavioural reference: PC value, a queue as the return stack, sticky flags
   logic [7:0] m_pc;
   logic [7:0] m_stk[$];
   bit m_ovf, m_unf;

   function automatic vec_t mk(bit rst_, bit w_, bit r_, bit i_, bit rel_, bit call_, bit ret_,
                               logic [7:0] off_, logic [7:0] bus_, logic [7:0] pc_,
                               bit f_, bit e_, bit o_, bit u_, bit cb_, logic [7:0] eb_);
      vec_t v;
      v.rst = rst_; v.w = w_; v.r = r_; v.i = i_; v.rel = rel_; v.call = call_; v.ret = ret_;
      v.off = off_; v.bus = bus_; v.pc = pc_; v.f = f_; v.e = e_; v.o = o_; v.u = u_;
      v.cb = cb_; v.eb = eb_;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // drive one cycle; returns the bus value seen before the edge
   task automatic apply(input bit rst_, input bit w_, input bit r_, input bit i_, input bit rel_,
                        input bit call_, input bit ret_, input logic [7:0] off_,
                        input logic [7:0] bus_, output logic [7:0] bus_seen);
      @(negedge clk);
      reset = !rst_; w = w_; r = r_; i = i_; rel = rel_; call = call_; ret = ret_;
      off = off_; bus_val = bus_; bus_en = w_ | call_;
      #2 bus_seen = pc_inout;
      @(posedge clk);
      #1;
   endtask

   task automatic model(input bit rst_, input bit w_, input bit i_, input bit rel_,
                        input bit call_, input bit ret_, input logic [7:0] off_, input logic [7:0] bus_);
      if (rst_) begin
         m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
      end else if (w_) m_pc = bus_;
      else if (call_) begin
         if (m_stk.size() == D) m_ovf = 1;
         else begin m_stk.push_back(m_pc + 8'd1); m_pc = bus_; end
      end else if (ret_) begin
         if (m_stk.size() == 0) m_unf = 1;
         else m_pc = m_stk.pop_back();
      end else if (rel_) m_pc = m_pc + off_;
      else if (i_) m_pc = m_pc + 8'd1;
   endtask

   initial begin
      logic [7:0] bs, pc_old;
      bit de;
      //                rst w r i rel cl rt off    bus    pc     f e o u cb eb
      tbl.push_back(mk(1, 0,0,0,0, 0,0, 8'h00, 8'h00, 8'h00, 0,1,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,1,0, 0,0, 8'h00, 8'h00, 8'h01, 0,1,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,1,0, 0,0, 8'h00, 8'h00, 8'h02, 0,1,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,1,0, 0,0, 8'h00, 8'h00, 8'h03, 0,1,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,1,0,0, 0,0, 8'h00, 8'h00, 8'h03, 0,1,0,0, 1, 8'h03));
      tbl.push_back(mk(0, 1,0,0,0, 0,0, 8'h00, 8'hFE, 8'hFE, 0,1,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,1,0, 0,0, 8'h00, 8'h00, 8'hFF, 0,1,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,1,0, 0,0, 8'h00, 8'h00, 8'h00, 0,1,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 1,0,0,0, 0,0, 8'h00, 8'h10, 8'h10, 0,1,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,0,1, 0,0, 8'hF0, 8'h00, 8'h00, 0,1,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,0,1, 0,0, 8'h05, 8'h00, 8'h05, 0,1,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 1,0,0,0, 0,0, 8'h00, 8'h20, 8'h20, 0,1,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,0,0, 1,0, 8'h00, 8'h80, 8'h80, 0,0,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,0,0, 0,1, 8'h00, 8'h00, 8'h21, 0,1,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,0,0, 1,0, 8'h00, 8'h40, 8'h40, 0,0,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,0,0, 1,0, 8'h00, 8'h50, 8'h50, 0,0,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,0,0, 1,0, 8'h00, 8'h60, 8'h60, 0,0,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,0,0, 1,0, 8'h00, 8'h70, 8'h70, 1,0,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,0,0, 1,0, 8'h00, 8'h90, 8'h70, 1,0,1,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,0,0, 0,1, 8'h00, 8'h00, 8'h61, 0,0,1,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,0,0, 0,1, 8'h00, 8'h00, 8'h51, 0,0,1,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,0,0, 0,1, 8'h00, 8'h00, 8'h41, 0,0,1,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,0,0, 0,1, 8'h00, 8'h00, 8'h22, 0,1,1,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,0,0, 0,1, 8'h00, 8'h00, 8'h22, 0,1,1,1, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,0,0, 1,1, 8'h00, 8'h33, 8'h33, 0,0,1,1, 0, 8'h00));
      tbl.push_back(mk(1, 0,0,0,0, 0,0, 8'h00, 8'h00, 8'h00, 0,1,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 1,0,0,0, 0,0, 8'h00, 8'h5A, 8'h5A, 0,1,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 1,1,1,0, 1,0, 8'h00, 8'h00, 8'h00, 0,1,0,0, 1, 8'h00));
      tbl.push_back(mk(0, 0,0,0,0, 1,0, 8'h00, 8'hC0, 8'hC0, 0,0,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,0,0, 1,0, 8'h00, 8'hC8, 8'hC8, 0,0,0,0, 0, 8'h00));
      tbl.push_back(mk(1, 0,0,1,0, 1,0, 8'h00, 8'h77, 8'h00, 0,1,0,0, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,0,0, 0,1, 8'h00, 8'h00, 8'h00, 0,1,0,1, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,1,1, 0,0, 8'h02, 8'h00, 8'h02, 0,1,0,1, 0, 8'h00));
      tbl.push_back(mk(0, 0,0,1,1, 0,1, 8'h04, 8'h00, 8'h02, 0,1,0,1, 0, 8'h00));
      tbl.push_back(mk(1, 0,1,0,0, 0,0, 8'h00, 8'h00, 8'h00, 0,1,0,0, 1, 8'h02));
      foreach (tbl[k]) begin
         apply(tbl[k].rst, tbl[k].w, tbl[k].r, tbl[k].i, tbl[k].rel, tbl[k].call, tbl[k].ret,
               tbl[k].off, tbl[k].bus, bs);
         chk($sformatf("vec%0d pc", k), pc_out, tbl[k].pc);
         chk($sformatf("vec%0d flags{f,e,o,u}", k), {4'h0, full, empty, ovf, unf},
             {4'h0, tbl[k].f, tbl[k].e, tbl[k].o, tbl[k].u});
         if (tbl[k].cb) chk($sformatf("vec%0d bus", k), bs, tbl[k].eb);
      end
      model(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      for (int n = 0; n < 500; n++) begin
         bit rs, ww, rr, ii, rl, cl, rt;
         logic [7:0] of, bv;
         rs = $urandom_range(0, 59) == 0;
         ww = $urandom_range(0, 9) == 0;
         cl = $urandom_range(0, 3) == 0;
         rt = $urandom_range(0, 3) == 0;
         rl = $urandom_range(0, 3) == 0;
         ii = $urandom_range(0, 1) == 1;
         rr = $urandom_range(0, 1) == 1;
         of = 8'($urandom);
         bv = 8'($urandom);
         pc_old = m_pc;
         de = rr && !ww && !cl;
         apply(rs, ww, rr, ii, rl, cl, rt, of, bv, bs);
         model(rs, ww, ii, rl, cl, rt, of, bv);
         chk("rand pc", pc_out, m_pc);
         chk("rand flags{f,e,o,u}", {4'h0, full, empty, ovf, unf},
             {4'h0, m_stk.size() == D, m_stk.size() == 0, m_ovf, m_unf});
         if (de) chk("rand bus read", bs, pc_old);
         else if (ww || cl) chk("rand bus load", bs, bv);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
